// File: rtl/mult_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encoding, FSM state type and small operation-decode helpers.
package mult_div_pkg;

    localparam logic [1:0] OpMult  = 2'b00;
    localparam logic [1:0] OpMultu = 2'b01;
    localparam logic [1:0] OpDiv   = 2'b10;
    localparam logic [1:0] OpDivu  = 2'b11;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StCalc = 2'b01,
        StFix  = 2'b10
    } state_e;

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OpMult) || (op == OpDiv);
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OpDiv) || (op == OpDivu);
    endfunction

endpackage

// File: rtl/mult_div_sign_fix.sv
// Conditional two's-complement negate, used when writing back signed results.
module mult_div_sign_fix #(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] value_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] value_o
);

    // Negate only when the recorded result sign asks for it.
    always_comb begin
        value_o = neg_i ? -value_i : value_i;
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// Divide support (DIV/DIVU) is built only when MULT_DIV_UNIT_DIVIDE_EN is
// defined; otherwise divide requests raise ILLEGAL_OP for one cycle.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [1:0]            OP,
    input  logic [DATA_WIDTH-1:0] OPERAND_A,
    input  logic [DATA_WIDTH-1:0] OPERAND_B,
    input  logic                  HI_WE,
    input  logic                  LO_WE,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    output logic [DATA_WIDTH-1:0] HI_OUT,
    output logic [DATA_WIDTH-1:0] LO_OUT,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  DIV_ZERO,
    output logic                  ILLEGAL_OP
);

    localparam int unsigned W    = DATA_WIDTH;
    localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);
    localparam logic [CntW-1:0] LastStep = CntW'(DATA_WIDTH - 1);
`ifdef MULT_DIV_UNIT_DIVIDE_EN
    localparam bit DivEn = 1'b1;
`else
    localparam bit DivEn = 1'b0;
`endif

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    work_hi_q, work_hi_d;
    logic [W-1:0]    work_lo_q, work_lo_d;
    logic [W-1:0]    hi_q, hi_d;
    logic [W-1:0]    lo_q, lo_d;
    logic            neg_lo_q, neg_lo_d;
    logic            done_q, done_d;
    logic            dz_q, dz_d;
    logic            ill_q, ill_d;

    logic            a_neg, b_neg;
    logic [W-1:0]    a_mag, b_mag;
    logic [W:0]      mul_sum;
    logic [2*W-1:0]  main_fixed;

`ifdef MULT_DIV_UNIT_DIVIDE_EN
    logic            is_div_q, is_div_d;
    logic            neg_hi_q, neg_hi_d;
    logic [W:0]      div_shift;
    logic [W-1:0]    div_diff;
    logic            div_ge;
    logic [W-1:0]    rem_fixed;
`endif

    // Operands are held as magnitudes; signs are only re-applied at writeback.
    always_comb begin
        a_neg = op_is_signed(OP) & OPERAND_A[W-1];
        b_neg = op_is_signed(OP) & OPERAND_B[W-1];
        a_mag = a_neg ? -OPERAND_A : OPERAND_A;
        b_mag = b_neg ? -OPERAND_B : OPERAND_B;
    end

    // Shift-add step: multiplier bits drain out of work_lo as the product fills in.
    always_comb begin
        mul_sum = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, b_q} : '0);
    end

`ifdef MULT_DIV_UNIT_DIVIDE_EN
    // Restoring step: the partial remainder is always below the divisor, so W bits suffice.
    always_comb begin
        div_shift = {work_hi_q, work_lo_q[W-1]};
        div_ge    = div_shift >= {1'b0, b_q};
        div_diff  = div_shift[W-1:0] - b_q;
    end

    mult_div_sign_fix #(
        .WIDTH(W)
    ) u_rem_fix (
        .value_i(work_hi_q),
        .neg_i  (neg_hi_q),
        .value_o(rem_fixed)
    );
`endif

    // Low half of a negated 2W value equals the negated low half, so this
    // instance serves both the product and the quotient.
    mult_div_sign_fix #(
        .WIDTH(2 * W)
    ) u_main_fix (
        .value_i({work_hi_q, work_lo_q}),
        .neg_i  (neg_lo_q),
        .value_o(main_fixed)
    );

    // Next-state and datapath control for IDLE -> CALC -> FIX.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        b_d       = b_q;
        work_hi_d = work_hi_q;
        work_lo_d = work_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        neg_lo_d  = neg_lo_q;
        done_d    = 1'b0;
        dz_d      = 1'b0;
        ill_d     = 1'b0;
`ifdef MULT_DIV_UNIT_DIVIDE_EN
        is_div_d  = is_div_q;
        neg_hi_d  = neg_hi_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (START) begin
                    // START always wins over same-edge HI/LO writes.
                    if (op_is_div(OP) && !DivEn) begin
                        ill_d = 1'b1;
                    end else begin
                        state_d   = StCalc;
                        cnt_d     = '0;
                        b_d       = b_mag;
                        work_hi_d = '0;
                        work_lo_d = a_mag;
                        neg_lo_d  = a_neg ^ b_neg;
`ifdef MULT_DIV_UNIT_DIVIDE_EN
                        is_div_d  = op_is_div(OP);
                        neg_hi_d  = a_neg;
`endif
                    end
                end else begin
                    if (HI_WE) hi_d = WR_DATA;
                    if (LO_WE) lo_d = WR_DATA;
                end
            end
            StCalc: begin
                cnt_d = cnt_q + CntW'(1);
`ifdef MULT_DIV_UNIT_DIVIDE_EN
                if (is_div_q) begin
                    work_hi_d = div_ge ? div_diff : div_shift[W-1:0];
                    work_lo_d = {work_lo_q[W-2:0], div_ge};
                end else
`endif
                begin
                    {work_hi_d, work_lo_d} = {mul_sum, work_lo_q[W-1:1]};
                end
                if (cnt_q == LastStep) state_d = StFix;
            end
            StFix: begin
                state_d = StIdle;
                done_d  = 1'b1;
`ifdef MULT_DIV_UNIT_DIVIDE_EN
                if (is_div_q) begin
                    // With a zero divisor the remainder is the dividend magnitude,
                    // and re-applying its sign returns OPERAND_A unchanged.
                    hi_d = rem_fixed;
                    if (b_q == '0) begin
                        lo_d = '1;
                        dz_d = 1'b1;
                    end else begin
                        lo_d = main_fixed[W-1:0];
                    end
                end else
`endif
                begin
                    {hi_d, lo_d} = main_fixed;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers, all cleared asynchronously.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            b_q       <= '0;
            work_hi_q <= '0;
            work_lo_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            neg_lo_q  <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
            ill_q     <= 1'b0;
`ifdef MULT_DIV_UNIT_DIVIDE_EN
            is_div_q  <= 1'b0;
            neg_hi_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            b_q       <= b_d;
            work_hi_q <= work_hi_d;
            work_lo_q <= work_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            neg_lo_q  <= neg_lo_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
            ill_q     <= ill_d;
`ifdef MULT_DIV_UNIT_DIVIDE_EN
            is_div_q  <= is_div_d;
            neg_hi_q  <= neg_hi_d;
`endif
        end
    end

    assign HI_OUT     = hi_q;
    assign LO_OUT     = lo_q;
    assign BUSY       = (state_q != StIdle);
    assign DONE       = done_q;
    assign DIV_ZERO   = dz_q;
    assign ILLEGAL_OP = ill_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: the driver pushes reference results,
// a negedge monitor pops and compares on DONE / ILLEGAL_OP.
// Honours MULT_DIV_UNIT_DIVIDE_EN the same way the design does.
module tb_mult_div_unit;
    import mult_div_pkg::*;

    localparam int unsigned W = 32;
`ifdef MULT_DIV_UNIT_DIVIDE_EN
    localparam bit DivEn = 1'b1;
`else
    localparam bit DivEn = 1'b0;
`endif

    logic         CLK = 1'b0;
    logic         RST;
    logic         START;
    logic [1:0]   OP;
    logic [W-1:0] OPERAND_A;
    logic [W-1:0] OPERAND_B;
    logic         HI_WE;
    logic         LO_WE;
    logic [W-1:0] WR_DATA;
    logic [W-1:0] HI_OUT;
    logic [W-1:0] LO_OUT;
    logic         BUSY;
    logic         DONE;
    logic         DIV_ZERO;
    logic         ILLEGAL_OP;

    typedef struct {
        bit           ill;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        bit           dz;
    } exp_t;

    exp_t         sb_q[$];
    exp_t         mon_e;
    int           n_checks = 0;
    int           n_fails  = 0;
    logic [W-1:0] model_hi = '0;
    logic [W-1:0] model_lo = '0;

    always #5 CLK = ~CLK;

    mult_div_unit #(
        .DATA_WIDTH(W)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .OP        (OP),
        .OPERAND_A (OPERAND_A),
        .OPERAND_B (OPERAND_B),
        .HI_WE     (HI_WE),
        .LO_WE     (LO_WE),
        .WR_DATA   (WR_DATA),
        .HI_OUT    (HI_OUT),
        .LO_OUT    (LO_OUT),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .DIV_ZERO  (DIV_ZERO),
        .ILLEGAL_OP(ILLEGAL_OP)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain arithmetic on the architectural meaning of each op.
    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        exp_t        e;
        int          sa;
        int          sb;
        longint      ps;
        logic [63:0] pu;
        sa    = a;
        sb    = b;
        e.ill = 1'b0;
        e.dz  = 1'b0;
        e.hi  = model_hi;
        e.lo  = model_lo;
        if (op_is_div(op) && !DivEn) begin
            e.ill = 1'b1;
            return e;
        end
        case (op)
            OpMult: begin
                ps = longint'(sa) * longint'(sb);
                {e.hi, e.lo} = ps;
            end
            OpMultu: begin
                pu = {32'b0, a} * {32'b0, b};
                {e.hi, e.lo} = pu;
            end
            default: begin
                if (b == '0) begin
                    e.lo = '1;
                    e.hi = a;
                    e.dz = 1'b1;
                end else if (op == OpDiv && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.lo = a;
                    e.hi = '0;
                end else if (op == OpDiv) begin
                    e.lo = sa / sb;
                    e.hi = sa % sb;
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0001;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Issue one operation; restart_at > 0 re-asserts START (plus stray writes)
    // at that busy edge, collide asserts HI_WE/LO_WE together with START.
    task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int restart_at, input bit collide);
        exp_t e;
        e = model(op, a, b);
        sb_q.push_back(e);
        if (!e.ill) begin
            model_hi = e.hi;
            model_lo = e.lo;
        end
        @(negedge CLK);
        START     = 1'b1;
        OP        = op;
        OPERAND_A = a;
        OPERAND_B = b;
        HI_WE     = collide;
        LO_WE     = collide;
        WR_DATA   = $urandom;
        @(negedge CLK);
        START     = 1'b0;
        HI_WE     = 1'b0;
        LO_WE     = 1'b0;
        OPERAND_A = $urandom;
        OPERAND_B = $urandom;
        if (e.ill) begin
            check("ill_busy_low", BUSY, 0);
            check("ill_pulse", ILLEGAL_OP, 1);
            @(negedge CLK);
            check("ill_one_cycle", ILLEGAL_OP, 0);
            check("ill_busy_still_low", BUSY, 0);
            check("ill_hi_hold", HI_OUT, model_hi);
            check("ill_lo_hold", LO_OUT, model_lo);
            return;
        end
        check("busy_after_start", BUSY, 1);
        for (int k = 1; k <= int'(W); k++) begin
            if (k == restart_at) begin
                START     = 1'b1;
                OP        = 2'($urandom);
                OPERAND_A = $urandom;
                OPERAND_B = $urandom;
                HI_WE     = 1'b1;
                LO_WE     = 1'b1;
                WR_DATA   = $urandom;
            end
            @(negedge CLK);
            START = 1'b0;
            HI_WE = 1'b0;
            LO_WE = 1'b0;
        end
        check("busy_at_edge_w", BUSY, 1);
        check("no_early_done", DONE, 0);
        @(negedge CLK);
        check("busy_low_in_done", BUSY, 0);
        check("done_latency", DONE, 1);
    endtask

    task automatic write_hilo(input logic [W-1:0] hv, input logic [W-1:0] lv);
        @(negedge CLK);
        HI_WE   = 1'b1;
        WR_DATA = hv;
        @(negedge CLK);
        HI_WE   = 1'b0;
        LO_WE   = 1'b1;
        WR_DATA = lv;
        @(negedge CLK);
        LO_WE    = 1'b0;
        model_hi = hv;
        model_lo = lv;
        check("mthi", HI_OUT, hv);
        check("mtlo", LO_OUT, lv);
    endtask

    // Monitor: every DONE / ILLEGAL_OP consumes exactly one expectation.
    always @(negedge CLK) begin
        if (!RST) begin
            if (DONE || ILLEGAL_OP) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_output", {DONE, ILLEGAL_OP}, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("kind_illegal", ILLEGAL_OP, mon_e.ill);
                    check("kind_done", DONE, !mon_e.ill);
                    check("hi_result", HI_OUT, mon_e.hi);
                    check("lo_result", LO_OUT, mon_e.lo);
                    check("div_zero", DIV_ZERO, mon_e.dz);
                end
            end else begin
                check("div_zero_outside_done", DIV_ZERO, 0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RST       = 1'b1;
        START     = 1'b0;
        OP        = '0;
        OPERAND_A = '0;
        OPERAND_B = '0;
        HI_WE     = 1'b0;
        LO_WE     = 1'b0;
        WR_DATA   = '0;
        #1;
        check("rst_hi", HI_OUT, 0);
        check("rst_lo", LO_OUT, 0);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_div_zero", DIV_ZERO, 0);
        check("rst_illegal", ILLEGAL_OP, 0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;

        do_op(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
        do_op(OpMult, 32'hFFFF_FFFD, 32'h0000_0007, 0, 1'b0);
        do_op(OpDiv, 32'hFFFF_FFF9, 32'h0000_0002, 0, 1'b0);
        do_op(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        do_op(OpDivu, 32'h0000_0064, 32'h0000_0000, 0, 1'b0);
        do_op(OpDiv, 32'hFFFF_FF9C, 32'h0000_0000, 0, 1'b0);

        // Second START mid-operation is ignored; result belongs to the first.
        do_op(OpMultu, 32'h1234_5678, 32'h9ABC_DEF0, 5, 1'b0);
        // START together with HI/LO writes: writes dropped.
        do_op(OpMultu, 32'h0000_0005, 32'h0000_0006, 0, 1'b1);
        do_op(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);

        // Abort by reset at edge 10: no DONE, registers cleared.
        @(negedge CLK);
        START     = 1'b1;
        OP        = OpMultu;
        OPERAND_A = 32'hDEAD_BEEF;
        OPERAND_B = 32'h0BAD_F00D;
        @(negedge CLK);
        START = 1'b0;
        repeat (9) @(negedge CLK);
        RST = 1'b1;
        #1;
        check("abort_busy", BUSY, 0);
        check("abort_hi", HI_OUT, 0);
        check("abort_lo", LO_OUT, 0);
        check("abort_done", DONE, 0);
        @(negedge CLK);
        RST      = 1'b0;
        model_hi = '0;
        model_lo = '0;
        repeat (W + 5) @(negedge CLK);
        check("abort_no_done_hi", HI_OUT, 0);
        do_op(OpMult, 32'h0000_0003, 32'hFFFF_FFFE, 0, 1'b0);

        write_hilo(32'h0000_1234, 32'h0000_5678);
        do_op(OpDivu, 32'h0000_0011, 32'h0000_0003, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [1:0]   op;
            logic [W-1:0] a;
            logic [W-1:0] b;
            int           rs;
            op = 2'($urandom_range(0, 3));
            a  = pick_operand();
            b  = ($urandom_range(0, 7) == 0) ? '0 : pick_operand();
            rs = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, W)) : 0;
            do_op(op, a, b, rs, 1'b0);
        end

        for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge CLK);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
